stream_demux_1xn: RTL and testbench

Parametrised 1-to-N stream demultiplexer with valid/ready handshakes and one registered output slot per channel. Routes each input beat to the output channel given by s_sel, which is sampled with the beat. Channels drain independently, so a stalled channel blocks only beats addressed to it. Sits between a single producer and N consumer blocks, and is the pipelined, flow-controlled successor to the combinational 1x8 demux.

---
 rtl/stream_demux_1xn_if.sv | 25 ++
 rtl/stream_demux_1xn.sv | 102 ++++++++++
 tb/tb_stream_demux_1xn.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1xn_if.sv
// rtl/stream_demux_1xn_if.sv - input beat and per-channel output bundle for stream_demux_1xn
interface stream_demux_1xn_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8
);
  localparam int SEL_W = $clog2(N_OUT);

  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_W-1:0]       s_data;
  logic [SEL_W-1:0]        s_sel;
  logic [N_OUT-1:0]        m_valid;
  logic [N_OUT-1:0]        m_ready;
  logic [N_OUT*DATA_W-1:0] m_data;

  modport slave (
    input  s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/stream_demux_1xn.sv
// rtl/stream_demux_1xn.sv - 1-to-N stream demux, one registered slot per channel
// Optional STREAM_DEMUX_STATS_EN adds saturating drop_cnt/busy_cnt outputs.
module stream_demux_1xn #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_demux_1xn_if.slave  sif,
  output logic               drop
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        busy_cnt
`endif
);

  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  slot_t             slot_q [N_OUT];
  slot_t             slot_d [N_OUT];
  logic [DATA_W-1:0] data_q [N_OUT];
  logic [N_OUT-1:0]  hit;
  logic [N_OUT-1:0]  stall;
  logic [N_OUT-1:0]  load;
  logic              sel_ok;
  logic              accept;

  // Out-of-range selects hit no channel, so they are always accepted and dropped.
  assign sel_ok = {1'b0, sif.s_sel} < N_OUT_L;

  always_comb begin
    hit   = '0;
    stall = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hit[k]   = sel_ok && (sif.s_sel == SEL_W'(k));
      stall[k] = (slot_q[k] == SLOT_FULL) && !sif.m_ready[k];
    end
  end

  assign sif.s_ready = ~|(hit & stall);
  assign accept      = sif.s_valid & sif.s_ready;
  assign load        = hit & {N_OUT{accept}};

  // A load wins over a drain so a popping slot can be refilled in the same cycle.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      slot_d[k] = slot_q[k];
      if (load[k]) begin
        slot_d[k] = SLOT_FULL;
      end else if (sif.m_ready[k]) begin
        slot_d[k] = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) begin
        slot_q[k] <= SLOT_EMPTY;
        data_q[k] <= '0;
      end
      drop <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        slot_q[k] <= slot_d[k];
        if (load[k]) begin
          data_q[k] <= sif.s_data;
        end
      end
      drop <= accept && !sel_ok;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign sif.m_valid[g]                   = (slot_q[g] == SLOT_FULL);
    assign sif.m_data[g*DATA_W +: DATA_W]   = data_q[g];
  end

`ifdef STREAM_DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      busy_cnt <= '0;
    end else begin
      if (accept && !sel_ok && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (sif.s_valid && !sif.s_ready && (busy_cnt != 16'hFFFF)) begin
        busy_cnt <= busy_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb/tb_stream_demux_1xn.sv - scoreboard bench for stream_demux_1xn (N_OUT=8 and N_OUT=5)
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  logic rst_n;
  logic drop;
  logic drop5;
  always #5 clk = ~clk;

  stream_demux_1xn_if #(.DATA_W(8), .N_OUT(8)) sif ();
  stream_demux_1xn_if #(.DATA_W(8), .N_OUT(5)) sif5 ();

`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] drop_cnt, busy_cnt, drop_cnt5, busy_cnt5;
`endif

  stream_demux_1xn #(.DATA_W(8), .N_OUT(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sif      (sif.slave),
    .drop     (drop)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .drop_cnt (drop_cnt),
    .busy_cnt (busy_cnt)
`endif
  );

  stream_demux_1xn #(.DATA_W(8), .N_OUT(5)) u_dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .sif      (sif5.slave),
    .drop     (drop5)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .drop_cnt (drop_cnt5),
    .busy_cnt (busy_cnt5)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [8][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ch_data(input int k);
    return sif.m_data[k*8 +: 8];
  endfunction

  // Scoreboard: a handshake on channel k completes at the coming rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (sif.m_valid[k] && sif.m_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("sb_extra_ch%0d", k), 64'(exp_q[k].size()), 64'd1);
          end else begin
            check($sformatf("sb_data_ch%0d", k), 64'(ch_data(k)), 64'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] data, input logic [2:0] sel);
    int tries;
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = data;
    sif.s_sel   = sel;
    tries = 0;
    #1;
    while (!sif.s_ready && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!sif.s_ready) begin
      check("send_timeout", 64'(sif.s_ready), 64'd1);
      sif.s_valid = 1'b0;
    end else begin
      exp_q[sel].push_back(data);
      @(posedge clk);
      #1;
      sif.s_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    sif.s_valid  = 1'b0;
    sif.s_data   = '0;
    sif.s_sel    = '0;
    sif.m_ready  = '1;
    sif5.s_valid = 1'b0;
    sif5.s_data  = '0;
    sif5.s_sel   = '0;
    sif5.m_ready = '1;
    #12;

    // Reset state
    check("rst_m_valid", 64'(sif.m_valid), 64'h0);
    check("rst_m_data", sif.m_data, 64'h0);
    check("rst_drop", 64'(drop), 64'h0);
    for (int s = 0; s < 8; s++) begin
      sif.s_sel = 3'(s);
      #1;
      check($sformatf("rst_s_ready_sel%0d", s), 64'(sif.s_ready), 64'h1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back beats to channels 0,1,2 with consumers ready
    send(8'hFA, 3'd0);
    check("b2b_mv0", 64'(sif.m_valid), 64'h01);
    send(8'h05, 3'd1);
    check("b2b_mv1", 64'(sif.m_valid), 64'h02);
    send(8'h10, 3'd2);
    check("b2b_mv2", 64'(sif.m_valid), 64'h04);
    @(posedge clk);
    #1;
    check("b2b_mv_idle", 64'(sif.m_valid), 64'h00);

    // Stalled channel 3: AA held, BB waits, then pop and refill in one cycle
    sif.m_ready = 8'hF7;
    send(8'hAA, 3'd3);
    check("stall_data_aa", 64'(ch_data(3)), 64'hAA);
    @(negedge clk);
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hBB;
    sif.s_sel   = 3'd3;
    #1;
    check("stall_s_ready_low", 64'(sif.s_ready), 64'h0);
    @(posedge clk);
    #1;
    check("stall_hold_data", 64'(ch_data(3)), 64'hAA);
    check("stall_hold_valid", 64'(sif.m_valid[3]), 64'h1);
    @(negedge clk);
    sif.m_ready[3] = 1'b1;
    #1;
    check("stall_s_ready_high", 64'(sif.s_ready), 64'h1);
    exp_q[3].push_back(8'hBB);
    @(posedge clk);
    #1;
    sif.s_valid = 1'b0;
    check("refill_data_bb", 64'(ch_data(3)), 64'hBB);
    check("refill_valid", 64'(sif.m_valid[3]), 64'h1);
    @(posedge clk);
    #1;
    check("refill_drained", 64'(sif.m_valid[3]), 64'h0);
`ifdef STREAM_DEMUX_STATS_EN
    check("busy_cnt", 64'(busy_cnt), 64'd1);
`endif

    // Channel 3 stalled full does not block channel 6
    sif.m_ready = 8'hB7;
    send(8'h33, 3'd3);
    send(8'h55, 3'd6);
    check("indep_valid", 64'(sif.m_valid), 64'h48);
    check("indep_data6", 64'(ch_data(6)), 64'h55);
    check("indep_data3", 64'(ch_data(3)), 64'h33);
    @(negedge clk);
    sif.m_ready = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("indep_drained", 64'(sif.m_valid), 64'h00);

    // N_OUT=5: out-of-range select is accepted and dropped
    @(negedge clk);
    sif5.s_valid = 1'b1;
    sif5.s_sel   = 3'd7;
    sif5.s_data  = 8'h99;
    #1;
    check("oor_s_ready", 64'(sif5.s_ready), 64'h1);
    @(posedge clk);
    #1;
    sif5.s_valid = 1'b0;
    check("oor_drop_pulse", 64'(drop5), 64'h1);
    check("oor_m_valid", 64'(sif5.m_valid), 64'h0);
    check("oor_no_drop8", 64'(drop), 64'h0);
`ifdef STREAM_DEMUX_STATS_EN
    check("oor_drop_cnt", 64'(drop_cnt5), 64'd1);
`endif
    @(posedge clk);
    #1;
    check("oor_drop_end", 64'(drop5), 64'h0);
    @(negedge clk);
    sif5.s_valid = 1'b1;
    sif5.s_sel   = 3'd4;
    sif5.s_data  = 8'h4C;
    @(posedge clk);
    #1;
    sif5.s_valid = 1'b0;
    check("n5_valid4", 64'(sif5.m_valid), 64'h10);
    check("n5_data4", 64'(sif5.m_data[39:32]), 64'h4C);
    check("n5_no_drop", 64'(drop5), 64'h0);

    // Asynchronous reset with channels 0 and 4 full
    sif.m_ready = 8'hEE;
    send(8'h01, 3'd0);
    send(8'h04, 3'd4);
    check("prerst_valid", 64'(sif.m_valid), 64'h11);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(sif.m_valid), 64'h00);
    check("async_rst_data", sif.m_data, 64'h0);
    for (int k = 0; k < 8; k++) exp_q[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    sif.m_ready = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_no_stale", 64'(sif.m_valid), 64'h00);
    send(8'h77, 3'd4);
    check("postrst_valid", 64'(sif.m_valid), 64'h10);
    check("postrst_data", 64'(ch_data(4)), 64'h77);

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("sb_left_ch%0d", k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
